// File: rtl/block_nest_pkg.sv
// Shared constants and types for the block nesting checker: character codes,
// error encodings, keyword tokens and stack entry types.
package block_nest_pkg;

    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNDER    = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_OVER     = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        TOK_NONE,
        TOK_BEGIN,
        TOK_END,
        TOK_CASE,
        TOK_ENDCASE
    } tok_e;

    typedef enum logic {
        ENT_B = 1'b0,
        ENT_C = 1'b1
    } ent_e;

    // Keywords right-aligned in a 7-character shift buffer, unused bytes zero
    localparam logic [55:0] KW_BEGIN   = {16'h0, "begin"};
    localparam logic [55:0] KW_END     = {32'h0, "end"};
    localparam logic [55:0] KW_CASE    = {24'h0, "case"};
    localparam logic [55:0] KW_ENDCASE = "endcase";

    function automatic logic [7:0] fold_char(input logic [7:0] c, input bit ci);
        if (ci && c >= 8'h41 && c <= 8'h5A)
            return c | 8'h20;
        return c;
    endfunction

endpackage

// File: rtl/block_nest_checker_classifier.sv
// Word scanner: splits the character stream on spaces, buffers up to seven
// characters and reports which keyword (if any) the pending word spells.
module nest_word_classifier
    import block_nest_pkg::*;
#(
    parameter int CASE_INS = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] char_i,
    output tok_e       tok_o
);

    typedef enum logic [1:0] {S_IDLE, S_WORD, S_LONG} state_e;

    state_e      state_q, state_d;
    logic [2:0]  len_q, len_d;
    logic [55:0] word_q, word_d;
    logic [7:0]  ch;

    always_comb begin
        ch      = fold_char(char_i, CASE_INS != 0);
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        if (ch == SPACE) begin
            state_d = S_IDLE;
            len_d   = '0;
            word_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_WORD;
                    len_d   = 3'd1;
                    word_d  = {48'h0, ch};
                end
                S_WORD: begin
                    if (len_q == 3'd7) begin
                        state_d = S_LONG;
                        len_d   = '0;
                        word_d  = '0;
                    end else begin
                        len_d  = len_q + 3'd1;
                        word_d = {word_q[47:0], ch};
                    end
                end
                default: state_d = S_LONG;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
        end
    end

    // Length gates the compare so embedded NUL bytes cannot alias a shorter keyword
    always_comb begin
        tok_o = TOK_NONE;
        if (state_q == S_WORD) begin
            case (len_q)
                3'd3:    if (word_q == KW_END)     tok_o = TOK_END;
                3'd4:    if (word_q == KW_CASE)    tok_o = TOK_CASE;
                3'd5:    if (word_q == KW_BEGIN)   tok_o = TOK_BEGIN;
                3'd7:    if (word_q == KW_ENDCASE) tok_o = TOK_ENDCASE;
                default: tok_o = TOK_NONE;
            endcase
        end
    end

endmodule

// File: rtl/block_nest_checker.sv
// Nesting checker: keeps a begin/case stack driven by keyword tokens, latches
// the first error, and previews the pending word to produce result.
module block_nest_checker
    import block_nest_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int CASE_INS = 1,
    parameter int DW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in,
    output logic          result,
    output logic [DW-1:0] depth,
    output logic [1:0]    err_code
);

    localparam int AW = $clog2(DEPTH);

    tok_e          tok;
    ent_e          stack_q [DEPTH];
    logic [DW-1:0] ptr_q, ptr_d;
    err_e          err_q, err_d;
    logic [AW-1:0] top_idx;
    ent_e          top_ent;
    ent_e          want_ent;
    logic          ev_push, ev_pop, commit;
    err_e          ev_err;

    nest_word_classifier #(
        .CASE_INS (CASE_INS)
    ) u_classifier (
        .clk_i  (clk),
        .rst_i  (reset),
        .char_i (in),
        .tok_o  (tok)
    );

    assign top_idx  = AW'(ptr_q - DW'(1));
    assign top_ent  = stack_q[top_idx];
    assign want_ent = (tok == TOK_CASE || tok == TOK_ENDCASE) ? ENT_C : ENT_B;

    // Evaluated on the pending token every cycle; the same decode drives both
    // the commit on a space and the result lookahead.
    always_comb begin
        ev_push = 1'b0;
        ev_pop  = 1'b0;
        ev_err  = ERR_NONE;
        case (tok)
            TOK_BEGIN, TOK_CASE: begin
                if (ptr_q == DW'(DEPTH)) ev_err  = ERR_OVER;
                else                     ev_push = 1'b1;
            end
            TOK_END, TOK_ENDCASE: begin
                if (ptr_q == '0)               ev_err = ERR_UNDER;
                else if (top_ent != want_ent)  ev_err = ERR_MISMATCH;
                else                           ev_pop = 1'b1;
            end
            default: ;
        endcase
    end

    assign commit = (err_q == ERR_NONE) && (in == SPACE);

    always_comb begin
        ptr_d = ptr_q;
        err_d = err_q;
        if (commit) begin
            if (ev_err != ERR_NONE) err_d = ev_err;
            else if (ev_push)       ptr_d = ptr_q + DW'(1);
            else if (ev_pop)        ptr_d = ptr_q - DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            err_q <= ERR_NONE;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && ev_push)
            stack_q[AW'(ptr_q)] <= want_ent;
    end

    assign depth    = ptr_q;
    assign err_code = err_q;
    assign result   = (err_q == ERR_NONE) && (ev_err == ERR_NONE) &&
                      ((ptr_q == '0 && !ev_push) || (ptr_q == DW'(1) && ev_pop));

endmodule
